// File: rtl/multicycle_control_fsm.sv
// Multicycle control FSM for the datapath-without-control: sequences fetch/decode/execute/writeback,
// traps on arithmetic overflow or illegal opcodes, and reports halt/exception status.
module multicycle_control_fsm #(
    parameter bit OVF_TRAP     = 1'b1,
    parameter bit ILLEGAL_TRAP = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] instruction,
    input  logic        overflow_input,
    output logic        MemWrite,
    output logic        PCWrite,
    output logic        SPWrite,
    output logic        InstWrite,
    output logic [1:0]  MemSrc,
    output logic [2:0]  MemDst,
    output logic [2:0]  PCSrc,
    output logic [2:0]  SPSrc,
    output logic        mary_write,
    output logic        shelley_write,
    output logic        comp_write,
    output logic        ra_write,
    output logic [1:0]  mary_src,
    output logic [1:0]  shelley_src,
    output logic        ra_src,
    output logic        SrcA,
    output logic [1:0]  SrcB,
    output logic [3:0]  AluOp,
    output logic        halted,
    output logic        exception,
    output logic [1:0]  exc_cause,
    output logic [3:0]  state_dbg
);

    typedef enum logic [3:0] {
        S_RST    = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_EXEC   = 4'd3,
        S_MEMWB  = 4'd4,
        S_POPRD  = 4'd5,
        S_TRAP   = 4'd6,
        S_HALTED = 4'd7
    } state_t;

    state_t      r_state;
    logic [3:0]  r_op;
    logic [1:0]  r_rd;
    logic        r_halted;
    logic        r_exception;
    logic [1:0]  r_exc_cause;

    logic        w_illegal;
    logic        w_ovf;
    logic        w_rd_we;
    logic [1:0]  w_rd_src;
    logic        w_jal_link;
    logic [1:0]  w_rd_memsrc;
    logic        w_unused;

    assign w_unused = ^instruction[9:0];

    // LW/POP into ra would need a memory source ra does not have, so they decode as illegal.
    assign w_illegal = (r_op == 4'hE) ||
                       (((r_op == 4'h6) || (r_op == 4'h9)) && (r_rd == 2'b11));
    assign w_ovf = OVF_TRAP && overflow_input &&
                   ((r_op == 4'h0) || (r_op == 4'h1) || (r_op == 4'h5));

    // rd encoding (comp=10, ra=11) differs from MemSrc encoding (ra=10, comp=11).
    assign w_rd_memsrc = r_rd[1] ? {1'b1, ~r_rd[0]} : r_rd;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= S_RST;
            r_halted    <= 1'b0;
            r_exception <= 1'b0;
            r_exc_cause <= 2'b00;
        end else begin
            case (r_state)
                S_RST:    r_state <= S_FETCH;
                S_FETCH:  r_state <= S_DECODE;
                S_DECODE: begin
                    r_op    <= instruction[15:12];
                    r_rd    <= instruction[11:10];
                    r_state <= S_EXEC;
                end
                S_EXEC: begin
                    if (w_illegal)
                        r_state <= ILLEGAL_TRAP ? S_TRAP : S_FETCH;
                    else if (w_ovf)
                        r_state <= S_TRAP;
                    else begin
                        case (r_op)
                            4'h6: r_state <= S_MEMWB;
                            4'h9: r_state <= S_POPRD;
                            4'hF: begin
                                r_state  <= S_HALTED;
                                r_halted <= 1'b1;
                            end
                            default: r_state <= S_FETCH;
                        endcase
                    end
                end
                S_MEMWB:  r_state <= S_FETCH;
                S_POPRD:  r_state <= S_MEMWB;
                S_TRAP: begin
                    // op/rd are still latched, so the cause is recovered here rather than stored.
                    r_exception <= 1'b1;
                    r_exc_cause <= w_illegal ? 2'b10 : 2'b01;
                    r_state     <= S_FETCH;
                end
                S_HALTED: r_state <= S_HALTED;
                default:  r_state <= S_RST;
            endcase
        end
    end

    always_comb begin
        MemWrite   = 1'b0;
        PCWrite    = 1'b0;
        SPWrite    = 1'b0;
        InstWrite  = 1'b0;
        MemSrc     = 2'b00;
        MemDst     = 3'b000;
        PCSrc      = 3'b000;
        SPSrc      = 3'b000;
        SrcA       = 1'b0;
        SrcB       = 2'b00;
        AluOp      = 4'b0000;
        w_rd_we    = 1'b0;
        w_rd_src   = 2'b00;
        w_jal_link = 1'b0;
        if (!reset) begin
            case (r_state)
                S_FETCH: begin
                    InstWrite = 1'b1;
                    PCWrite   = 1'b1;
                end
                S_EXEC: begin
                    if (!w_illegal) begin
                        case (r_op)
                            4'h0, 4'h1, 4'h2, 4'h3, 4'h4: begin
                                AluOp   = r_op;
                                w_rd_we = !w_ovf;
                            end
                            4'h5: begin
                                SrcB    = 2'b01;
                                w_rd_we = !w_ovf;
                            end
                            4'h6: MemDst = 3'b010;
                            4'h7: begin
                                MemDst   = 3'b010;
                                MemSrc   = w_rd_memsrc;
                                MemWrite = 1'b1;
                            end
                            4'h8: begin
                                MemDst   = 3'b001;
                                MemSrc   = w_rd_memsrc;
                                MemWrite = 1'b1;
                                SPWrite  = 1'b1;
                            end
                            4'h9: begin
                                SPWrite = 1'b1;
                                SPSrc   = 3'b001;
                            end
                            4'hA: begin
                                PCWrite = 1'b1;
                                PCSrc   = 3'b001;
                            end
                            4'hB: begin
                                PCWrite    = 1'b1;
                                PCSrc      = 3'b001;
                                w_jal_link = 1'b1;
                            end
                            4'hC: begin
                                PCWrite = 1'b1;
                                PCSrc   = 3'b010;
                            end
                            4'hD: begin
                                PCWrite = 1'b1;
                                PCSrc   = 3'b011;
                            end
                            default: ;
                        endcase
                    end
                end
                S_POPRD: MemDst = 3'b001;
                S_MEMWB: begin
                    w_rd_we  = 1'b1;
                    w_rd_src = 2'b01;
                end
                S_TRAP: begin
                    PCWrite = 1'b1;
                    PCSrc   = 3'b100;
                end
                default: ;
            endcase
        end
    end

    assign mary_write    = w_rd_we && (r_rd == 2'b00);
    assign shelley_write = w_rd_we && (r_rd == 2'b01);
    assign comp_write    = w_rd_we && (r_rd == 2'b10);
    assign ra_write      = (w_rd_we && (r_rd == 2'b11)) || w_jal_link;
    assign mary_src      = mary_write ? w_rd_src : 2'b00;
    assign shelley_src   = shelley_write ? w_rd_src : 2'b00;
    assign ra_src        = w_jal_link;

    assign halted    = r_halted;
    assign exception = r_exception;
    assign exc_cause = r_exc_cause;
    assign state_dbg = r_state;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench: stimulus pushes hand-written per-cycle control expectations, a negedge monitor
// pops and compares them against the full DUT output vector.
module tb_multicycle_control_fsm;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] instruction = 16'h0000;
    logic        overflow_input = 1'b0;
    logic        MemWrite, PCWrite, SPWrite, InstWrite;
    logic [1:0]  MemSrc;
    logic [2:0]  MemDst, PCSrc, SPSrc;
    logic        mary_write, shelley_write, comp_write, ra_write;
    logic [1:0]  mary_src, shelley_src;
    logic        ra_src, SrcA;
    logic [1:0]  SrcB;
    logic [3:0]  AluOp;
    logic        halted, exception;
    logic [1:0]  exc_cause;
    logic [3:0]  state_dbg;

    multicycle_control_fsm #(.OVF_TRAP(1'b1), .ILLEGAL_TRAP(1'b1)) dut (
        .clock(clock), .reset(reset), .instruction(instruction), .overflow_input(overflow_input),
        .MemWrite(MemWrite), .PCWrite(PCWrite), .SPWrite(SPWrite), .InstWrite(InstWrite),
        .MemSrc(MemSrc), .MemDst(MemDst), .PCSrc(PCSrc), .SPSrc(SPSrc),
        .mary_write(mary_write), .shelley_write(shelley_write), .comp_write(comp_write),
        .ra_write(ra_write), .mary_src(mary_src), .shelley_src(shelley_src), .ra_src(ra_src),
        .SrcA(SrcA), .SrcB(SrcB), .AluOp(AluOp), .halted(halted), .exception(exception),
        .exc_cause(exc_cause), .state_dbg(state_dbg)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [3:0] st;
        logic       mem_w, pc_w, sp_w, ins_w;
        logic [1:0] mem_src;
        logic [2:0] mem_dst, pc_src, sp_src;
        logic       m_we, s_we, c_we, r_we;
        logic [1:0] m_src, s_src;
        logic       r_src, src_a;
        logic [1:0] src_b;
        logic [3:0] alu;
        logic       halt, exc;
        logic [1:0] cause;
    } exp_t;

    typedef struct {
        int    cyc;
        string nm;
        exp_t  e;
    } ent_t;

    ent_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    logic       s_exc = 1'b0;
    logic [1:0] s_cause = 2'b00;
    logic       s_halt = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic exp_t act();
        exp_t a;
        a = '{st: state_dbg, mem_w: MemWrite, pc_w: PCWrite, sp_w: SPWrite, ins_w: InstWrite,
              mem_src: MemSrc, mem_dst: MemDst, pc_src: PCSrc, sp_src: SPSrc,
              m_we: mary_write, s_we: shelley_write, c_we: comp_write, r_we: ra_write,
              m_src: mary_src, s_src: shelley_src, r_src: ra_src, src_a: SrcA, src_b: SrcB,
              alu: AluOp, halt: halted, exc: exception, cause: exc_cause};
        return a;
    endfunction

    always @(negedge clock) begin : monitor
        ent_t t;
        exp_t a;
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            t = q.pop_front();
            a = act();
            checks++;
            if (t.cyc != cyc || a !== t.e) begin
                errors++;
                $display("FAIL %s cyc=%0d (expected cyc %0d) got=%h want=%h", t.nm, cyc, t.cyc, a, t.e);
            end
        end
    end

    function automatic exp_t z(input logic [3:0] st);
        exp_t e;
        e = '0;
        e.st = st;
        e.halt = s_halt;
        e.exc = s_exc;
        e.cause = s_cause;
        return e;
    endfunction

    function automatic exp_t fe();
        exp_t e;
        e = z(4'd1);
        e.ins_w = 1'b1;
        e.pc_w = 1'b1;
        return e;
    endfunction

    function automatic exp_t with_wr(input exp_t ein, input logic [1:0] rd, input logic [1:0] src);
        exp_t e;
        e = ein;
        case (rd)
            2'b00: begin e.m_we = 1'b1; e.m_src = src; end
            2'b01: begin e.s_we = 1'b1; e.s_src = src; end
            2'b10: e.c_we = 1'b1;
            default: e.r_we = 1'b1;
        endcase
        return e;
    endfunction

    function automatic exp_t trap_e();
        exp_t e;
        e = z(4'd6);
        e.pc_w = 1'b1;
        e.pc_src = 3'b100;
        return e;
    endfunction

    task automatic step(input string nm, input exp_t e);
        ent_t t;
        t.cyc = cyc;
        t.nm = nm;
        t.e = e;
        q.push_back(t);
        @(posedge clock);
        #1;
    endtask

    task automatic fetch_decode(input logic [15:0] ins);
        instruction = ins;
        step("fetch", fe());
        step("decode", z(4'd2));
    endtask

    // ALU/ADDI table: instruction, AluOp, rd, SrcB, overflow_input driven in EXEC
    logic [15:0] t_ins  [5] = '{16'h1800, 16'h2400, 16'h3000, 16'h4C00, 16'h5C00};
    logic [3:0]  t_alu  [5] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h0};
    logic [1:0]  t_rd   [5] = '{2'b10, 2'b01, 2'b00, 2'b11, 2'b11};
    logic [1:0]  t_srcb [5] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b01};
    logic        t_ovf  [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    // jumps: instruction, PCSrc, links ra
    logic [15:0] j_ins  [4] = '{16'hA000, 16'hB000, 16'hC000, 16'hD000};
    logic [2:0]  j_src  [4] = '{3'b001, 3'b001, 3'b010, 3'b011};
    logic        j_link [4] = '{1'b0, 1'b1, 1'b0, 1'b0};

    initial begin : stim
        exp_t e;
        @(posedge clock);
        #1;
        step("rst_a", z(4'd0));
        reset = 1'b0;
        step("rst_b", z(4'd0));

        // ADD shelley
        fetch_decode(16'h0400);
        e = with_wr(z(4'd3), 2'b01, 2'b00);
        step("add_ex", e);

        // ADD shelley with overflow: write suppressed, trap
        fetch_decode(16'h0400);
        overflow_input = 1'b1;
        step("addovf_ex", z(4'd3));
        overflow_input = 1'b0;
        step("addovf_trap", trap_e());
        s_exc = 1'b1;
        s_cause = 2'b01;

        for (int i = 0; i < 5; i++) begin
            fetch_decode(t_ins[i]);
            overflow_input = t_ovf[i];
            e = z(4'd3);
            e.alu = t_alu[i];
            e.src_b = t_srcb[i];
            e = with_wr(e, t_rd[i], 2'b00);
            step("alu_ex", e);
            overflow_input = 1'b0;
        end

        // LW mary
        fetch_decode(16'h6000);
        e = z(4'd3); e.mem_dst = 3'b010;
        step("lw_ex", e);
        step("lw_mb", with_wr(z(4'd4), 2'b00, 2'b01));

        // SW comp
        fetch_decode(16'h7800);
        e = z(4'd3); e.mem_dst = 3'b010; e.mem_src = 2'b11; e.mem_w = 1'b1;
        step("sw_ex", e);

        // PUSH ra
        fetch_decode(16'h8C00);
        e = z(4'd3); e.mem_dst = 3'b001; e.mem_src = 2'b10; e.mem_w = 1'b1; e.sp_w = 1'b1;
        step("push_ex", e);

        // POP shelley
        fetch_decode(16'h9400);
        e = z(4'd3); e.sp_w = 1'b1; e.sp_src = 3'b001;
        step("pop_ex", e);
        e = z(4'd5); e.mem_dst = 3'b001;
        step("pop_rd", e);
        step("pop_mb", with_wr(z(4'd4), 2'b01, 2'b01));

        for (int i = 0; i < 4; i++) begin
            fetch_decode(j_ins[i]);
            e = z(4'd3); e.pc_w = 1'b1; e.pc_src = j_src[i];
            e.r_we = j_link[i]; e.r_src = j_link[i];
            step("jump_ex", e);
        end

        // opcode E: illegal, cause overwritten to 10
        fetch_decode(16'hE000);
        step("ill_ex", z(4'd3));
        step("ill_trap", trap_e());
        s_cause = 2'b10;

        // POP ra: illegal
        fetch_decode(16'h9C00);
        overflow_input = 1'b1;
        step("popra_ex", z(4'd3));
        overflow_input = 1'b0;
        step("popra_trap", trap_e());

        // ADDI mary overflow: cause back to 01
        fetch_decode(16'h5000);
        overflow_input = 1'b1;
        e = z(4'd3); e.src_b = 2'b01;
        step("addiovf_ex", e);
        overflow_input = 1'b0;
        step("addiovf_trap", trap_e());
        s_cause = 2'b01;

        // reset during LW writeback
        fetch_decode(16'h6000);
        e = z(4'd3); e.mem_dst = 3'b010;
        step("lwrst_ex", e);
        reset = 1'b1;
        step("lwrst_mb", z(4'd4));
        reset = 1'b0;
        s_exc = 1'b0;
        s_cause = 2'b00;
        step("lwrst_rst", z(4'd0));

        // HALT
        fetch_decode(16'hF000);
        step("halt_ex", z(4'd3));
        s_halt = 1'b1;
        for (int i = 0; i < 20; i++) begin
            instruction = 16'h0400 + 16'(i);
            overflow_input = i[0];
            step("halted", z(4'd7));
        end
        overflow_input = 1'b0;
        reset = 1'b1;
        step("halt_rst", z(4'd7));
        s_halt = 1'b0;
        reset = 1'b0;
        step("halt_rst_rst", z(4'd0));
        step("post_fetch", fe());

        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d want=0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
